// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: computes A+B+Cin LSB-first through one full adder and a carry flop,
// with a fixed N-edge latency and a one-cycle done pulse.
module serial_adder_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] S,
  output logic         Cout
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   a_sr, b_sr, sum_sr, sum_nxt;
  logic           carry, sum_bit, carry_nxt, last_bit;
  logic [CW-1:0]  cnt;

  // Single 1-bit full adder on the operand LSBs.
  assign sum_bit   = a_sr[0] ^ b_sr[0] ^ carry;
  assign carry_nxt = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
  assign sum_nxt   = (sum_sr >> 1) | (N'(sum_bit) << (N - 1));
  assign last_bit  = (cnt == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = ADD;
      ADD: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      S      <= '0;
      Cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sr  <= A;
          b_sr  <= B;
          carry <= Cin;
          cnt   <= '0;
        end
        ADD: begin
          sum_sr <= sum_nxt;
          carry  <= carry_nxt;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          cnt    <= cnt + 1'b1;
          // Results become visible only once the final bit is in.
          if (last_bit) begin
            S    <= sum_nxt;
            Cout <= carry_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (N=8) against an arithmetic reference model.
module tb_serial_adder_ctrl;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n, start, Cin;
  logic [N-1:0] A, B;
  logic         busy, done, Cout;
  logic [N-1:0] S;

  int checks   = 0;
  int failures = 0;

  serial_adder_ctrl #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Cin(Cin),
    .busy(busy), .done(done), .S(S), .Cout(Cout)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: {Cout,S} is the plain (N+1)-bit sum.
  function automatic logic [N:0] ref_sum(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
    return (N+1)'(a) + (N+1)'(b) + (N+1)'(c);
  endfunction

  // Drives one operation from IDLE and observes it through the return to IDLE.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                        input bit zero_after, output logic [N:0] res, output int lat,
                        output bit busy_ok, output bit hold_ok, output bit tail_ok);
    logic [N-1:0] prev_s;
    logic         prev_c;
    prev_s = S; prev_c = Cout;
    A = a; B = b; Cin = c; start = 1'b1;
    tick;
    start = 1'b0;
    if (zero_after) begin A = '0; B = '0; Cin = 1'b0; end
    else begin A = N'($urandom); B = N'($urandom); Cin = 1'($urandom); end
    busy_ok = busy; hold_ok = 1'b1; lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick;
      if (!busy) busy_ok = 1'b0;
      if (done) begin lat = k; break; end
      if (S !== prev_s || Cout !== prev_c) hold_ok = 1'b0;
    end
    res = {Cout, S};
    tick;
    tail_ok = !busy && !done;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b1; A = 8'hFF; B = 8'hFF; Cin = 1'b1;
    tick; tick;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (S !== '0) begin failures++; $display("FAIL reset_S got=%h exp=00", S); end
    checks++; if (Cout !== 1'b0) begin failures++; $display("FAIL reset_Cout got=%b exp=0", Cout); end
    rst_n = 1'b1; start = 1'b0;
    tick;
  endtask

  task automatic test_vectors;
    logic [N-1:0] va[4] = '{8'h00, 8'hFF, 8'hFF, 8'h5A};
    logic [N-1:0] vb[4] = '{8'h00, 8'h01, 8'hFF, 8'h3C};
    logic         vc[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [N:0]   vexp[4] = '{9'h000, 9'h100, 9'h1FF, 9'h097};
    logic [N:0] res; int lat; bit bo, ho, to;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], vc[i], i == 3, res, lat, bo, ho, to);
      checks++; if (res !== vexp[i]) begin failures++; $display("FAIL vec%0d_sum got=%h exp=%h", i, res, vexp[i]); end
      checks++; if (lat != N) begin failures++; $display("FAIL vec%0d_latency got=%0d exp=%0d", i, lat, N); end
      checks++; if (!bo || !ho || !to) begin failures++; $display("FAIL vec%0d_handshake busy_ok=%b hold_ok=%b tail_ok=%b exp=111", i, bo, ho, to); end
    end
  endtask

  task automatic test_start_held;
    logic [N:0] ops[$];
    logic [N:0] got, exp_r;
    int npulse = 0, bad = 0;
    bit exp_busy, exp_done;
    A = N'($urandom); B = N'($urandom); Cin = 1'($urandom); start = 1'b1;
    for (int t = 0; t < 30; t++) begin
      ops.push_back(ref_sum(A, B, Cin));
      tick;
      exp_busy = (t % 10) <= 8;
      exp_done = (t % 10) == 8;
      if (busy !== exp_busy || done !== exp_done) begin
        bad++;
        $display("FAIL held_t%0d busy=%b done=%b exp_busy=%b exp_done=%b", t, busy, done, exp_busy, exp_done);
      end
      if (done) begin
        npulse++;
        got = {Cout, S};
        exp_r = (t >= N) ? ops[t-N] : 'x;
        checks++; if (got !== exp_r) begin failures++; $display("FAIL held_result_t%0d got=%h exp=%h", t, got, exp_r); end
      end
      A = N'($urandom); B = N'($urandom); Cin = 1'($urandom);
    end
    start = 1'b0;
    tick;
    checks++; if (bad != 0) begin failures++; $display("FAIL held_timing bad_cycles=%0d exp=0", bad); end
    checks++; if (npulse != 3) begin failures++; $display("FAIL held_pulses got=%0d exp=3", npulse); end
  endtask

  task automatic test_reset_mid;
    logic [N:0] res; int lat; bit bo, ho, to; int seen = 0;
    A = 8'h12; B = 8'h34; Cin = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL midreset_ctrl busy=%b done=%b exp=0/0", busy, done); end
    checks++; if ({Cout, S} !== '0) begin failures++; $display("FAIL midreset_result got=%h exp=000", {Cout, S}); end
    for (int k = 0; k < 12; k++) begin
      tick;
      if (done || busy || {Cout, S} !== '0) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL midreset_residue cycles=%0d exp=0", seen); end
    run_op(8'h12, 8'h34, 1'b0, 1'b0, res, lat, bo, ho, to);
    checks++; if (res !== 9'h046) begin failures++; $display("FAIL midreset_rerun got=%h exp=046", res); end
  endtask

  task automatic test_back_to_back;
    logic [N-1:0] a, b; logic c;
    logic [N:0] res, exp_r; int lat; bit bo, ho, to;
    int bad_sum = 0, bad_tim = 0;
    for (int i = 0; i < 1000; i++) begin
      a = N'($urandom); b = N'($urandom); c = 1'($urandom);
      exp_r = ref_sum(a, b, c);
      run_op(a, b, c, 1'b0, res, lat, bo, ho, to);
      if (res !== exp_r) begin
        bad_sum++;
        if (bad_sum <= 5) $display("FAIL rand%0d_sum a=%h b=%h c=%b got=%h exp=%h", i, a, b, c, res, exp_r);
      end
      if (lat != N || !bo || !ho || !to) bad_tim++;
    end
    checks++; if (bad_sum != 0) begin failures++; $display("FAIL rand_sum_total got=%0d exp=0", bad_sum); end
    checks++; if (bad_tim != 0) begin failures++; $display("FAIL rand_timing_total got=%0d exp=0", bad_tim); end
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_start_held;
    test_reset_mid;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
